uart_tx_fifo: RTL

- Buffered RS-232 transmitter for the host link: absorbs bursts of bytes from the internal command/response path into a FIFO and serialises them back-to-back on TxD.
- Adds a valid/ready input handshake, optional parity, selectable stop bits and line-break generation.
- Sits beside async_receiver on the same serial port and runs in the same clock domain.

---
 rtl/uart_tx_fifo.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered RS-232 transmitter. Bytes arrive over a valid/ready handshake,
//   are queued in a FifoDepth-entry FIFO and are serialised back-to-back on
//   TxD as start / 8 data (LSB first) / optional parity / StopBits stop bits.
//   A held send_break drives the line low at the next frame boundary and is
//   followed by one idle-high recovery bit period.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   in_data     byte to transmit
//   in_valid    in_data is valid
//   in_ready    FIFO can accept a byte (low while reset is high)
//   send_break  request a line break
//   TxD         registered serial output, idle high
//   busy        frame, break or recovery in progress, or FIFO non-empty
//   fifo_count  number of bytes held in the FIFO
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int ClkFrequency = 32000000,
    parameter int Baud         = 2000000,
    parameter int FifoDepth    = 16,
    parameter int StopBits     = 2,
    parameter int ParityEn     = 0,
    parameter int ParityOdd    = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         send_break,
    output logic                         TxD,
    output logic                         busy,
    output logic [$clog2(FifoDepth):0]   fifo_count
);

    localparam int BitCycles = ClkFrequency / Baud;
    localparam int AW        = $clog2(FifoDepth);
    localparam int CW        = (BitCycles > 1) ? $clog2(BitCycles) : 1;

    localparam logic [CW-1:0] CNT_MAX   = CW'(BitCycles - 1);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(FifoDepth);
    localparam logic [2:0]    LAST_STOP = 3'(StopBits - 1);
    localparam logic          PAR_ODD   = (ParityOdd != 0);

    // Configuration guards: refuse to elaborate a design that cannot work.
    if (ClkFrequency % Baud != 0) begin : g_bad_baud
        $error("uart_tx_fifo: ClkFrequency must be an integer multiple of Baud");
    end
    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FifoDepth must be a power of 2 and at least 2");
    end
    if (StopBits != 1 && StopBits != 2) begin : g_bad_stop
        $error("uart_tx_fifo: StopBits must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK,
        S_RECOVER
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [7:0]    mem_q [FifoDepth];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push;
    logic          pop;
    logic          fifo_empty;

    assign in_ready   = (count_q < DEPTH) && !reset;
    assign push       = in_valid && in_ready;
    assign fifo_empty = (count_q == '0);
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Pointers wrap naturally because FifoDepth is a power of 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------- shifter
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          txd_q;
    logic          busy_q;
    logic          txd_d;
    logic          busy_d;
    logic          bit_end;
    logic          last_stop;

    assign bit_end   = (cnt_q == '0);
    assign last_stop = (bit_idx_q == LAST_STOP);

    // A new frame is started from IDLE, or straight out of the last stop bit
    // (no idle gap), or at the end of break recovery so that the recovery gap
    // is exactly one bit period. A pending break always wins over the FIFO.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty && !send_break) begin
            case (state_q)
                S_IDLE:    pop = 1'b1;
                S_STOP:    pop = bit_end && last_stop;
                S_RECOVER: pop = bit_end;
                default:   pop = 1'b0;
            endcase
        end
    end

    // TxD is registered from the current state, so the line follows the
    // state register by one clock: a pop on edge N gives the start bit on N+1.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            S_START:  txd_d = 1'b0;
            S_BREAK:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_q[bit_idx_q];
            S_PARITY: txd_d = (^shift_q) ^ PAR_ODD;
            default:  txd_d = 1'b1;
        endcase
    end

    assign busy_d = (state_q != S_IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            txd_q  <= txd_d;
            busy_q <= busy_d;
            if (pop) begin
                shift_q   <= mem_q[rd_ptr_q];
                state_q   <= S_START;
                cnt_q     <= CNT_MAX;
                bit_idx_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (send_break) begin
                            state_q <= S_BREAK;
                        end
                    end
                    S_START: begin
                        if (bit_end) begin
                            state_q   <= S_DATA;
                            cnt_q     <= CNT_MAX;
                            bit_idx_q <= '0;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            cnt_q <= CNT_MAX;
                            if (bit_idx_q == 3'd7) begin
                                bit_idx_q <= '0;
                                state_q   <= (ParityEn != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    S_PARITY: begin
                        if (bit_end) begin
                            state_q   <= S_STOP;
                            cnt_q     <= CNT_MAX;
                            bit_idx_q <= '0;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    S_STOP: begin
                        if (bit_end) begin
                            cnt_q <= CNT_MAX;
                            if (last_stop) begin
                                state_q <= S_IDLE;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    S_BREAK: begin
                        if (!send_break) begin
                            state_q <= S_RECOVER;
                            cnt_q   <= CNT_MAX;
                        end
                    end
                    S_RECOVER: begin
                        if (bit_end) begin
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign TxD  = txd_q;
    assign busy = busy_q;

endmodule
